memory_access_unit: RTL and testbench

- Data memory stage that serves the control unit's memory handshake.
- Consumes MOV, RW, SIG and DL from the control unit, plus the MAR address and MDR write data from the datapath.
- Performs byte, halfword or word transfers against an internal byte-wide RAM using a multi-cycle state machine, then returns MOC plus read data destined for MDR.
- MOC feeds the control unit's condition mux, which holds the microinstruction until MOC is seen.

---
 rtl/memory_access_unit_pkg.sv | 65 ++++++
 rtl/memory_access_unit_byte_ram.sv | 24 ++
 rtl/memory_access_unit.sv | 181 ++++++++++++++++++
 tb/tb_memory_access_unit.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/memory_access_unit_pkg.sv
// Shared definitions for the data-memory access stage: data-length and
// direction encodings, FSM state type and small datapath helpers.
package mem_defs;

  localparam logic [1:0] DL_BYTE  = 2'b00;
  localparam logic [1:0] DL_HALF  = 2'b01;
  localparam logic [1:0] DL_WORD  = 2'b10;
  localparam logic [1:0] DL_DWORD = 2'b11;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_XFER = 2'b10,
    ST_DONE = 2'b11
  } state_e;

  // Number of bytes moved for a data length; doubleword is handled as a word.
  function automatic logic [2:0] dl_bytes(input logic [1:0] dl);
    logic [2:0] n;
    case (dl)
      DL_BYTE: n = 3'd1;
      DL_HALF: n = 3'd2;
      default: n = 3'd4;
    endcase
    return n;
  endfunction

  // Halfwords need an even address, words a 4-byte aligned one.
  function automatic logic is_misaligned(input logic [1:0] dl, input logic [1:0] addr_lo);
    logic bad;
    case (dl)
      DL_BYTE: bad = 1'b0;
      DL_HALF: bad = addr_lo[0];
      default: bad = (addr_lo != 2'b00);
    endcase
    return bad;
  endfunction

  // Left-justify write data so the first (most significant) byte sits in [31:24].
  function automatic logic [31:0] align_wdata(input logic [1:0] dl, input logic [31:0] d);
    logic [31:0] r;
    case (dl)
      DL_BYTE: r = {d[7:0], 24'd0};
      DL_HALF: r = {d[15:0], 16'd0};
      default: r = d;
    endcase
    return r;
  endfunction

  // Zero- or sign-extend an assembled read value; words pass through untouched.
  function automatic logic [31:0] extend_read(input logic [31:0] v, input logic [1:0] dl,
                                              input logic sg);
    logic [31:0] r;
    case (dl)
      DL_BYTE: r = sg ? {{24{v[7]}}, v[7:0]} : {24'd0, v[7:0]};
      DL_HALF: r = sg ? {{16{v[15]}}, v[15:0]} : {16'd0, v[15:0]};
      default: r = v;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/memory_access_unit_byte_ram.sv
// Byte-wide RAM: synchronous write, asynchronous read, single shared address.
// Contents are deliberately not reset.
module byte_ram #(
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [7:0]        din,
  output logic [7:0]        dout
);

  logic [7:0] mem [0:(2**ADDR_W)-1];

  // Store one byte on the rising edge when write-enabled.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= din;
    end
  end

  assign dout = mem[addr];

endmodule

// File: rtl/memory_access_unit.sv
// Data memory stage: accepts a MOV request from the control unit, moves
// 1/2/4 bytes big-endian through byte_ram one byte per cycle after an
// access latency, and answers with a registered MOC / read data handshake.
module memory_access_unit
  import mem_defs::*;
#(
  parameter int ADDR_W      = 9,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mov,
  input  logic        rw,
  input  logic        sig,
  input  logic [1:0]  dl,
  input  logic [31:0] addr,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        moc,
  output logic        align_err
);

  localparam int CNT_W = 16;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((WAIT_CYCLES > 0) ? (WAIT_CYCLES - 1) : 0);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        rem_q, rem_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              rw_q, rw_d;
  logic              sig_q, sig_d;
  logic [1:0]        dl_q, dl_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       asm_q, asm_d;
  logic [31:0]       data_out_q, data_out_d;
  logic              moc_q, moc_d;
  logic              align_err_q, align_err_d;

  logic              ram_we_s;
  logic [7:0]        ram_dout_s;
  logic              unused_addr_s;

  // Address bits above the RAM depth are ignored, giving modulo wrap.
  assign unused_addr_s = ^addr[31:ADDR_W];

  byte_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk  (clk),
    .we   (ram_we_s),
    .addr (addr_q),
    .din  (wdata_q[31:24]),
    .dout (ram_dout_s)
  );

  // Next-state and datapath computation for the request/transfer sequencer.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    addr_d      = addr_q;
    rw_d        = rw_q;
    sig_d       = sig_q;
    dl_d        = dl_q;
    wdata_d     = wdata_q;
    asm_d       = asm_q;
    data_out_d  = data_out_q;
    moc_d       = moc_q;
    align_err_d = align_err_q;
    ram_we_s    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (mov) begin
          rw_d    = rw;
          sig_d   = sig;
          dl_d    = dl;
          addr_d  = addr[ADDR_W-1:0];
          wdata_d = align_wdata(dl, data_in);
          asm_d   = 32'd0;
          rem_d   = dl_bytes(dl);
          cnt_d   = {CNT_W{1'b0}};
          if (is_misaligned(dl, addr[1:0])) begin
            // Reject without touching RAM or data_out.
            state_d     = ST_DONE;
            moc_d       = 1'b1;
            align_err_d = 1'b1;
          end else if (WAIT_CYCLES > 0) begin
            state_d = ST_WAIT;
          end else begin
            state_d = ST_XFER;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_WAIT: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = {CNT_W{1'b0}};
          state_d = ST_XFER;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = ST_WAIT;
        end
      end

      ST_XFER: begin
        // One byte per cycle, most significant byte at the lowest address.
        ram_we_s = (rw_q == RW_WRITE);
        wdata_d  = {wdata_q[23:0], 8'd0};
        asm_d    = {asm_q[23:0], ram_dout_s};
        addr_d   = addr_q + ADDR_W'(1);
        rem_d    = rem_q - 3'd1;
        if (rem_q == 3'd1) begin
          state_d     = ST_DONE;
          moc_d       = 1'b1;
          align_err_d = 1'b0;
          if (rw_q == RW_READ) begin
            data_out_d = extend_read({asm_q[23:0], ram_dout_s}, dl_q, sig_q);
          end else begin
            data_out_d = data_out_q;
          end
        end else begin
          state_d = ST_XFER;
        end
      end

      ST_DONE: begin
        // Hold the handshake until the control unit drops mov.
        if (!mov) begin
          state_d     = ST_IDLE;
          moc_d       = 1'b0;
          align_err_d = 1'b0;
        end else begin
          state_d = ST_DONE;
        end
      end

      default: begin
        state_d     = ST_IDLE;
        moc_d       = 1'b0;
        align_err_d = 1'b0;
      end
    endcase
  end

  // State and output registers; asynchronous reset abandons any transfer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= {CNT_W{1'b0}};
      rem_q       <= 3'd0;
      addr_q      <= {ADDR_W{1'b0}};
      rw_q        <= RW_READ;
      sig_q       <= 1'b0;
      dl_q        <= DL_BYTE;
      wdata_q     <= 32'd0;
      asm_q       <= 32'd0;
      data_out_q  <= 32'd0;
      moc_q       <= 1'b0;
      align_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      addr_q      <= addr_d;
      rw_q        <= rw_d;
      sig_q       <= sig_d;
      dl_q        <= dl_d;
      wdata_q     <= wdata_d;
      asm_q       <= asm_d;
      data_out_q  <= data_out_d;
      moc_q       <= moc_d;
      align_err_q <= align_err_d;
    end
  end

  assign data_out  = data_out_q;
  assign moc       = moc_q;
  assign align_err = align_err_q;

endmodule

// File: tb/tb_memory_access_unit.sv
// Directed bench for memory_access_unit (ADDR_W=9, WAIT_CYCLES=2).
module tb_memory_access_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        mov = 1'b0;
  logic        rw = 1'b0;
  logic        sig = 1'b0;
  logic [1:0]  dl = 2'b00;
  logic [31:0] addr = 32'd0;
  logic [31:0] data_in = 32'd0;
  logic [31:0] data_out;
  logic        moc;
  logic        align_err;

  int tests_run = 0;
  int tests_failed = 0;

  memory_access_unit #(.ADDR_W(9), .WAIT_CYCLES(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .mov       (mov),
    .rw        (rw),
    .sig       (sig),
    .dl        (dl),
    .addr      (addr),
    .data_in   (data_in),
    .data_out  (data_out),
    .moc       (moc),
    .align_err (align_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chk_mem(input string tag, input int a, input logic [7:0] e);
    check(tag, {24'd0, dut.u_ram.mem[a]}, {24'd0, e});
  endtask

  // Issue one request, measure edges from accept to moc, optionally hold mov
  // for extra cycles, then release and confirm the return to idle.
  task automatic run_op(input logic r, input logic s, input logic [1:0] d,
                        input logic [31:0] a, input logic [31:0] wd, input int hold,
                        output int lat, output logic aerr);
    @(negedge clk);
    rw = r; sig = s; dl = d; addr = a; data_in = wd; mov = 1'b1;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
      if (lat == 1) begin
        // Captured at accept; these changes must be ignored.
        data_in = ~wd;
        addr    = a ^ 32'h4;
      end
    end while (!moc && lat < 40);
    aerr = align_err;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("hold_moc", {31'd0, moc}, 32'd1);
    end
    @(negedge clk);
    mov = 1'b0;
    @(posedge clk); #1;
    check("release_moc", {31'd0, moc}, 32'd0);
    check("release_aerr", {31'd0, align_err}, 32'd0);
  endtask

  initial begin
    int   lat;
    logic aerr;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_moc", {31'd0, moc}, 32'd0);
    check("rst_aerr", {31'd0, align_err}, 32'd0);
    check("rst_dout", data_out, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Word write then read back
    run_op(1'b0, 1'b0, 2'b10, 32'h0000_0010, 32'h1234_5678, 0, lat, aerr);
    check("wr_word_lat", lat, 32'd7);
    check("wr_word_aerr", {31'd0, aerr}, 32'd0);
    chk_mem("m010", 32'h010, 8'h12);
    chk_mem("m011", 32'h011, 8'h34);
    chk_mem("m012", 32'h012, 8'h56);
    chk_mem("m013", 32'h013, 8'h78);
    check("wr_word_dout", data_out, 32'd0);
    run_op(1'b1, 1'b0, 2'b10, 32'h0000_0010, 32'h0, 0, lat, aerr);
    check("rd_word_lat", lat, 32'd7);
    check("rd_word_dout", data_out, 32'h1234_5678);

    // Byte write/read with and without sign extension
    run_op(1'b0, 1'b0, 2'b00, 32'h0000_0021, 32'hAAAA_AA85, 0, lat, aerr);
    check("wr_byte_lat", lat, 32'd4);
    chk_mem("m021", 32'h021, 8'h85);
    run_op(1'b1, 1'b1, 2'b00, 32'h0000_0021, 32'h0, 0, lat, aerr);
    check("rd_sbyte_dout", data_out, 32'hFFFF_FF85);
    run_op(1'b1, 1'b0, 2'b00, 32'h0000_0021, 32'h0, 0, lat, aerr);
    check("rd_ubyte_lat", lat, 32'd4);
    check("rd_ubyte_dout", data_out, 32'h0000_0085);

    // Halfword write and reads
    run_op(1'b0, 1'b0, 2'b01, 32'h0000_0030, 32'h0000_BEEF, 0, lat, aerr);
    check("wr_half_lat", lat, 32'd5);
    chk_mem("m030", 32'h030, 8'hBE);
    chk_mem("m031", 32'h031, 8'hEF);
    run_op(1'b1, 1'b1, 2'b01, 32'h0000_0030, 32'h0, 0, lat, aerr);
    check("rd_shalf_dout", data_out, 32'hFFFF_BEEF);
    run_op(1'b1, 1'b0, 2'b01, 32'h0000_0030, 32'h0, 0, lat, aerr);
    check("rd_uhalf_dout", data_out, 32'h0000_BEEF);
    run_op(1'b1, 1'b1, 2'b10, 32'h0000_0010, 32'h0, 0, lat, aerr);
    check("rd_word_nosx", data_out, 32'h1234_5678);

    // Misaligned requests: immediate reject, RAM and data_out untouched
    run_op(1'b1, 1'b0, 2'b10, 32'h0000_0022, 32'h0, 0, lat, aerr);
    check("mis_rd_lat", lat, 32'd1);
    check("mis_rd_aerr", {31'd0, aerr}, 32'd1);
    check("mis_rd_dout", data_out, 32'h1234_5678);
    run_op(1'b0, 1'b0, 2'b01, 32'h0000_0031, 32'h0000_1111, 0, lat, aerr);
    check("mis_wr_lat", lat, 32'd1);
    check("mis_wr_aerr", {31'd0, aerr}, 32'd1);
    chk_mem("mis_m031", 32'h031, 8'hEF);
    chk_mem("mis_m030", 32'h030, 8'hBE);

    // Handshake: moc held while mov stays high
    run_op(1'b1, 1'b0, 2'b00, 32'h0000_0013, 32'h0, 5, lat, aerr);
    check("hold_lat", lat, 32'd4);
    check("hold_dout", data_out, 32'h0000_0078);

    // Address wrap modulo 512
    run_op(1'b0, 1'b0, 2'b10, 32'h0000_01FC, 32'hA1B2_C3D4, 0, lat, aerr);
    chk_mem("m1FC", 32'h1FC, 8'hA1);
    chk_mem("m1FF", 32'h1FF, 8'hD4);
    run_op(1'b0, 1'b0, 2'b10, 32'h0000_0200, 32'h1122_3344, 0, lat, aerr);
    chk_mem("m000", 32'h000, 8'h11);
    chk_mem("m003", 32'h003, 8'h44);
    chk_mem("m1FC_keep", 32'h1FC, 8'hA1);
    run_op(1'b1, 1'b0, 2'b10, 32'h0000_0000, 32'h0, 0, lat, aerr);
    check("rd_wrap_dout", data_out, 32'h1122_3344);

    // mov dropped right after accept: operation still completes
    @(negedge clk);
    rw = 1'b1; sig = 1'b1; dl = 2'b00; addr = 32'h0000_0021; mov = 1'b1;
    @(posedge clk);
    @(negedge clk);
    mov = 1'b0;
    lat = 1;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!moc && lat < 40);
    check("drop_lat", lat, 32'd4);
    check("drop_dout", data_out, 32'hFFFF_FF85);
    @(posedge clk); #1;
    check("drop_moc_low", {31'd0, moc}, 32'd0);

    // Reset during the transfer of a word write
    run_op(1'b0, 1'b0, 2'b10, 32'h0000_0040, 32'h0102_0304, 0, lat, aerr);
    run_op(1'b1, 1'b0, 2'b10, 32'h0000_0000, 32'h0, 0, lat, aerr);
    @(negedge clk);
    rw = 1'b0; sig = 1'b0; dl = 2'b10; addr = 32'h0000_0040; data_in = 32'h5566_7788;
    mov = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    mov = 1'b0;
    #1;
    check("rst_mid_moc", {31'd0, moc}, 32'd0);
    check("rst_mid_dout", data_out, 32'd0);
    chk_mem("rst_m040", 32'h040, 8'h55);
    chk_mem("rst_m041", 32'h041, 8'h66);
    chk_mem("rst_m042", 32'h042, 8'h03);
    chk_mem("rst_m043", 32'h043, 8'h04);
    @(negedge clk);
    reset = 1'b1;
    run_op(1'b1, 1'b0, 2'b10, 32'h0000_0040, 32'h0, 0, lat, aerr);
    check("post_rst_lat", lat, 32'd7);
    check("post_rst_dout", data_out, 32'h5566_0304);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
